// File: rtl/ysyx_25040111_rf_pkg.sv
// Shared constants and types for the register file with scoreboard.
package ysyx_25040111_rf_pkg;

  localparam int RF_XLEN_DEF = 32;
  localparam int RF_NREG_DEF = 16;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/ysyx_25040111_rf_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per architectural register.
// Priority: flush over everything; set over writeback clear; x0 never busy.
module ysyx_25040111_rf_scoreboard
  import ysyx_25040111_rf_pkg::*;
#(
  parameter int NREG = RF_NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            run,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_addr,
  input  logic            sb_flush,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] busy_q;

  // Next busy vector; updates are ignored until the init sweep finishes.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (sb_flush) begin
        busy_d = '0;
      end else begin
        if (wen) busy_d[waddr] = 1'b0;
        if (sb_set) busy_d[sb_addr] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/ysyx_25040111_rf_sb.sv
// Parametrised register file with N combinational read ports, one write
// port, post-reset zeroing sweep and integrated busy-bit scoreboard.
// Optional same-cycle write-to-read forwarding: YSYX_25040111_RF_BYPASS_EN.
//
//   state | meaning
//   INIT  | sweep writes zero to rf[idx] each cycle; ports read as 0
//   RUN   | normal operation, ready = 1
module ysyx_25040111_rf_sb
  import ysyx_25040111_rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN_DEF,
  parameter int NREG = RF_NREG_DEF,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic                ready,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD-1:0]      ren,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  input  logic                sb_flush
);

  rf_state_e       state_d, state_q;
  logic [AW-1:0]   idx_d, idx_q;
  logic            rf_we_d;
  logic [AW-1:0]   rf_wa_d;
  logic [XLEN-1:0] rf_wd_d;
  logic [XLEN-1:0] rf_q [NREG];
  logic [NREG-1:0] busy;
  logic            running;

  assign running = (state_q == RUN);
  assign ready   = running;

  // Sweep FSM and array write-port selection (sweep owns the port in INIT).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rf_we_d = 1'b0;
    rf_wa_d = waddr;
    rf_wd_d = wdata;
    case (state_q)
      INIT: begin
        rf_we_d = 1'b1;
        rf_wa_d = idx_q;
        rf_wd_d = '0;
        idx_d   = idx_q + AW'(1);
        if (idx_q == AW'(NREG - 1)) state_d = RUN;
      end
      RUN: begin
        rf_we_d = wen && (waddr != '0);
      end
      default: state_d = INIT;
    endcase
  end

  // FSM state and sweep index.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Storage array: deliberately unreset so it can map onto distributed RAM.
  always_ff @(posedge clock) begin
    if (rf_we_d) rf_q[rf_wa_d] <= rf_wd_d;
  end

  ysyx_25040111_rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clock    (clock),
    .reset_n  (reset_n),
    .run      (running),
    .wen      (wen),
    .waddr    (waddr),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .sb_flush (sb_flush),
    .busy     (busy)
  );

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    logic          byp;

    assign ra  = raddr[g*AW +: AW];
    assign hit = running && ren[g] && (ra != '0);
`ifdef YSYX_25040111_RF_BYPASS_EN
    assign byp = hit && wen && (waddr == ra);
`else
    assign byp = 1'b0;
`endif
    assign rdata[g*XLEN +: XLEN] = !hit ? '0 : (byp ? wdata : rf_q[ra]);
    assign rbusy[g]              = hit && !byp && busy[ra];
  end

endmodule

// File: tb/tb_ysyx_25040111_rf_sb.sv
// Self-checking bench for ysyx_25040111_rf_sb with a behavioural model.
module tb_ysyx_25040111_rf_sb;

  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int NRD  = 2;
  localparam int AW   = 4;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                ready;
  logic                wen;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic [NRD-1:0]      ren;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic                sb_flush;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_mem [16];
  bit   [15:0] mdl_busy;
  bit          mdl_run;

  always #5 clock = ~clock;

  ysyx_25040111_rf_sb #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ready    (ready),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .ren      (ren),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .sb_flush (sb_flush)
  );

  task automatic idle();
    wen = 0; waddr = 0; wdata = 0; ren = 0; raddr = 0;
    sb_set = 0; sb_addr = 0; sb_flush = 0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) mdl_mem[r] = 32'h0;
    mdl_busy = '0;
    mdl_run  = 0;
  endtask

  // Advance one clock edge, applying the architectural effect of the inputs.
  task automatic step();
    @(posedge clock);
    if (mdl_run) begin
      if (sb_flush) mdl_busy = '0;
      else begin
        if (wen && waddr != 0) mdl_busy[waddr] = 0;
        if (sb_set && sb_addr != 0) mdl_busy[sb_addr] = 1;
      end
      if (wen && waddr != 0) mdl_mem[waddr] = wdata;
    end
    @(negedge clock);
  endtask

  function automatic logic [31:0] exp_rd(int p);
    logic [3:0] a;
    a = raddr[p*4 +: 4];
    if (!mdl_run || !ren[p] || a == 0) return 32'h0;
`ifdef YSYX_25040111_RF_BYPASS_EN
    if (wen && waddr == a) return wdata;
`endif
    return mdl_mem[a];
  endfunction

  function automatic logic exp_rb(int p);
    logic [3:0] a;
    a = raddr[p*4 +: 4];
    if (!mdl_run || !ren[p] || a == 0) return 1'b0;
`ifdef YSYX_25040111_RF_BYPASS_EN
    if (wen && waddr == a) return 1'b0;
`endif
    return mdl_busy[a];
  endfunction

  task automatic sweep_check(input string tag);
    for (int k = 0; k <= 17; k++) begin
      #1;
      checks++;
      if (ready !== (k >= 16)) begin
        errors++;
        $display("FAIL %s_ready k=%0d got %b want %b", tag, k, ready, (k >= 16));
      end
      if (k < 16) begin
        checks++;
        if (rdata !== 64'h0 || rbusy !== 2'b00) begin
          errors++;
          $display("FAIL %s_init_read k=%0d got %h/%b want 0/00", tag, k, rdata, rbusy);
        end
      end
      if (k <= 15) begin
        wen = 1; waddr = 4'($urandom_range(1, 15)); wdata = $urandom;
        sb_set = 1; sb_addr = 4'($urandom_range(1, 15)); sb_flush = 0;
        ren = 2'b11; raddr = 8'($urandom);
      end else begin
        idle();
      end
      @(negedge clock);
    end
    mdl_run = 1;
  endtask

  task automatic test_reset();
    idle();
    ren = 2'b11; raddr = 8'h35;
    reset_n = 0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (ready !== 1'b0 || rdata !== 64'h0 || rbusy !== 2'b00) begin
      errors++;
      $display("FAIL reset_state got ready=%b rdata=%h rbusy=%b want 0/0/00", ready, rdata, rbusy);
    end
    @(negedge clock);
    reset_n = 1;
    sweep_check("reset");
  endtask

  task automatic test_init_zero();
    for (int a = 1; a < 16; a++) begin
      idle();
      ren = 2'b11; raddr = {4'(a), 4'(16 - a)};
      #1;
      checks++;
      if (rdata !== 64'h0 || rbusy !== 2'b00) begin
        errors++;
        $display("FAIL init_zero x%0d got %h/%b want 0/00", a, rdata, rbusy);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_write_read();
    idle();
    wen = 1; waddr = 5; wdata = 32'hDEADBEEF;
    step();
    idle();
    ren = 2'b01; raddr = 8'h05;
    #1;
    checks++;
    if (rdata[31:0] !== 32'hDEADBEEF || rbusy[0] !== 1'b0) begin
      errors++;
      $display("FAIL write_read x5 got %h/%b want deadbeef/0", rdata[31:0], rbusy[0]);
    end
    ren = 2'b00;
    #1;
    checks++;
    if (rdata !== 64'h0) begin
      errors++;
      $display("FAIL ren_low got %h want 0", rdata);
    end
    @(negedge clock);
  endtask

  task automatic test_x0();
    idle();
    wen = 1; waddr = 0; wdata = 32'h1234;
    sb_set = 1; sb_addr = 0;
    step();
    idle();
    ren = 2'b11; raddr = 8'h00;
    #1;
    checks++;
    if (rdata !== 64'h0 || rbusy !== 2'b00) begin
      errors++;
      $display("FAIL x0_read got %h/%b want 0/00", rdata, rbusy);
    end
    @(negedge clock);
  endtask

  task automatic test_bypass();
    idle();
    wen = 1; waddr = 7; wdata = 32'h11112222;
    step();
    idle();
    sb_set = 1; sb_addr = 7;
    step();
    idle();
    wen = 1; waddr = 7; wdata = 32'hA5A5A5A5;
    ren = 2'b10; raddr = 8'h70;
    #1;
    checks++;
`ifdef YSYX_25040111_RF_BYPASS_EN
    if (rdata[63:32] !== 32'hA5A5A5A5 || rbusy[1] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_fwd got %h/%b want a5a5a5a5/0", rdata[63:32], rbusy[1]);
    end
`else
    if (rdata[63:32] !== 32'h11112222 || rbusy[1] !== 1'b1) begin
      errors++;
      $display("FAIL bypass_off got %h/%b want 11112222/1", rdata[63:32], rbusy[1]);
    end
`endif
    step();
    idle();
    ren = 2'b10; raddr = 8'h70;
    #1;
    checks++;
    if (rdata[63:32] !== 32'hA5A5A5A5 || rbusy[1] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_after got %h/%b want a5a5a5a5/0", rdata[63:32], rbusy[1]);
    end
    @(negedge clock);
  endtask

  task automatic test_scoreboard();
    idle();
    sb_set = 1; sb_addr = 3;
    ren = 2'b01; raddr = 8'h03;
    #1;
    checks++;
    if (rbusy[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_not_forwarded got %b want 0", rbusy[0]);
    end
    step();
    idle();
    ren = 2'b01; raddr = 8'h03;
    #1;
    checks++;
    if (rbusy[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_set got %b want 1", rbusy[0]);
    end
    idle();
    wen = 1; waddr = 3; wdata = 32'h10;
    step();
    idle();
    ren = 2'b01; raddr = 8'h03;
    #1;
    checks++;
    if (rbusy[0] !== 1'b0 || rdata[31:0] !== 32'h10) begin
      errors++;
      $display("FAIL sb_clear got %h/%b want 00000010/0", rdata[31:0], rbusy[0]);
    end
    idle();
    wen = 1; waddr = 3; wdata = 32'h22;
    sb_set = 1; sb_addr = 3;
    step();
    idle();
    ren = 2'b01; raddr = 8'h03;
    #1;
    checks++;
    if (rbusy[0] !== 1'b1 || rdata[31:0] !== 32'h22) begin
      errors++;
      $display("FAIL sb_set_wins got %h/%b want 00000022/1", rdata[31:0], rbusy[0]);
    end
    @(negedge clock);
  endtask

  task automatic test_flush();
    idle(); sb_set = 1; sb_addr = 2; step();
    idle(); sb_set = 1; sb_addr = 4; step();
    idle(); sb_set = 1; sb_addr = 9; step();
    idle();
    ren = 2'b11; raddr = 8'h92;
    #1;
    checks++;
    if (rbusy !== 2'b11) begin
      errors++;
      $display("FAIL flush_pre got %b want 11", rbusy);
    end
    idle();
    sb_flush = 1; sb_set = 1; sb_addr = 6;
    wen = 1; waddr = 12; wdata = 32'h77;
    step();
    idle();
    for (int a = 1; a < 16; a++) begin
      ren = 2'b11; raddr = {4'(a), 4'(a)};
      #1;
      checks++;
      if (rbusy !== 2'b00) begin
        errors++;
        $display("FAIL flush_clear x%0d got %b want 00", a, rbusy);
      end
    end
    raddr = 8'h0C; ren = 2'b01;
    #1;
    checks++;
    if (rdata[31:0] !== 32'h77) begin
      errors++;
      $display("FAIL flush_write got %h want 00000077", rdata[31:0]);
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wen      = ($urandom_range(0, 1) == 1);
      waddr    = 4'($urandom);
      wdata    = $urandom;
      sb_set   = ($urandom_range(0, 1) == 1);
      sb_addr  = 4'($urandom);
      sb_flush = ($urandom_range(0, 15) == 0);
      ren      = 2'($urandom);
      raddr    = 8'($urandom);
      if ($urandom_range(0, 3) == 0) raddr[7:4] = waddr;
      #1;
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (rdata[p*32 +: 32] !== exp_rd(p) || rbusy[p] !== exp_rb(p)) begin
          errors++;
          $display("FAIL random n=%0d port%0d got %h/%b want %h/%b", n, p,
                   rdata[p*32 +: 32], rbusy[p], exp_rd(p), exp_rb(p));
        end
      end
      step();
    end
    idle();
  endtask

  task automatic test_reset_mid_sweep();
    idle();
    @(negedge clock);
    reset_n = 0;
    model_reset();
    @(negedge clock);
    reset_n = 1;
    for (int k = 0; k < 8; k++) @(negedge clock);
    reset_n = 0;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ready got %b want 0", ready);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1;
    sweep_check("mid");
    ren = 2'b11; raddr = 8'h35;
    #1;
    checks++;
    if (rdata !== 64'h0 || rbusy !== 2'b00) begin
      errors++;
      $display("FAIL mid_rezero got %h/%b want 0/00", rdata, rbusy);
    end
    @(negedge clock);
  endtask

  initial begin
    idle();
    model_reset();
    @(negedge clock);
    test_reset();
    test_init_zero();
    test_write_read();
    test_x0();
    test_bypass();
    test_scoreboard();
    test_flush();
    test_random();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
